term_ctrl: RTL and testbench

TERM_CTRL -- requirements
Module: term_ctrl

---
 rtl/term_ctrl.sv | 138 +++++++++++++
 tb/tb_term_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_ctrl.sv
// term_ctrl: character terminal controller that writes printable bytes into text VRAM,
// handles CR/LF/BS/FF cursor control, and scrolls the screen or clears it.
module term_ctrl #(
    parameter int         LINES = 17,
    parameter int         COLS  = 60,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_char,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    input  logic [7:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic [4:0]  o_row,
    output logic [5:0]  o_col,
    output logic        o_busy
);
    localparam logic [4:0] LAST_ROW = 5'(LINES - 1);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL} state_t;

    state_t     state, state_n;
    logic [4:0] row, row_n, sr, sr_n;
    logic [5:0] col, col_n, sc, sc_n;
    logic [7:0] char_r, char_n;

    assign o_row   = row;
    assign o_col   = col;
    assign o_ready = state == IDLE;
    assign o_busy  = !o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            sr     <= '0;
            sc     <= '0;
            char_r <= '0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            col    <= col_n;
            sr     <= sr_n;
            sc     <= sc_n;
            char_r <= char_n;
        end
    end

    // sr/sc serve both as scroll counters and as fill counters; IDLE parks them at zero
    always_comb begin
        state_n     = state;
        row_n       = row;
        col_n       = col;
        sr_n        = sr;
        sc_n        = sc;
        char_n      = char_r;
        o_vram_ce   = 1'b0;
        o_vram_wre  = 1'b0;
        o_vram_addr = '0;
        o_vram_din  = '0;
        case (state)
            IDLE: begin
                sr_n = '0;
                sc_n = '0;
                if (i_valid) begin
                    if (i_char >= 8'h20 && i_char <= 8'h7E) begin
                        char_n  = i_char;
                        state_n = WRITE;
                    end else if (i_char == 8'h0D) begin
                        col_n = '0;
                    end else if (i_char == 8'h0A) begin
                        if (row == LAST_ROW) state_n = SCROLL_RD;
                        else row_n = row + 5'd1;
                    end else if (i_char == 8'h08) begin
                        col_n = (col != '0) ? col - 6'd1 : col;
                    end else if (i_char == 8'h0C) begin
                        row_n   = '0;
                        col_n   = '0;
                        state_n = FILL;
                    end
                end
            end
            WRITE: begin
                o_vram_ce   = 1'b1;
                o_vram_wre  = 1'b1;
                o_vram_addr = {row, col};
                o_vram_din  = char_r;
                state_n     = IDLE;
                if (col != LAST_COL) begin
                    col_n = col + 6'd1;
                end else begin
                    col_n = '0;
                    if (row != LAST_ROW) row_n = row + 5'd1;
                    else state_n = SCROLL_RD;
                end
            end
            SCROLL_RD: begin
                o_vram_ce   = 1'b1;
                o_vram_addr = {sr + 5'd1, sc};
                state_n     = SCROLL_WR;
            end
            SCROLL_WR: begin
                o_vram_ce   = 1'b1;
                o_vram_wre  = 1'b1;
                o_vram_addr = {sr, sc};
                o_vram_din  = i_vram_dout;
                state_n     = SCROLL_RD;
                if (sc != LAST_COL) begin
                    sc_n = sc + 6'd1;
                end else begin
                    sc_n = '0;
                    sr_n = sr + 5'd1;
                    if (sr == LAST_ROW - 5'd1) state_n = FILL;
                end
            end
            FILL: begin
                o_vram_ce   = 1'b1;
                o_vram_wre  = 1'b1;
                o_vram_addr = {sr, sc};
                o_vram_din  = BLANK;
                if (sc != LAST_COL) begin
                    sc_n = sc + 6'd1;
                end else begin
                    sc_n = '0;
                    if (sr == LAST_ROW) state_n = IDLE;
                    else sr_n = sr + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: vector table, directed corner sequences and random traffic against a screen model.
module tb_term_ctrl;
    localparam int         LINES      = 17;
    localparam int         COLS       = 60;
    localparam logic [7:0] BLANK      = 8'h20;
    localparam int         SCROLL_CYC = (LINES - 1) * COLS * 2 + COLS;
    localparam int         CLEAR_CYC  = LINES * COLS;
    localparam int         LIMIT      = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ch = 8'h00;
    logic        vld = 1'b0;
    logic        ready, busy_o, ce, wre;
    logic [10:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout = 8'h00;
    logic [4:0]  row;
    logic [5:0]  col;

    int errors = 0;
    int checks = 0;

    always #21 clk = ~clk;

    term_ctrl #(.LINES(LINES), .COLS(COLS), .BLANK(BLANK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_char(ch), .i_valid(vld), .o_ready(ready),
        .o_vram_addr(addr), .o_vram_din(din), .i_vram_dout(dout), .o_vram_ce(ce),
        .o_vram_wre(wre), .o_row(row), .o_col(col), .o_busy(busy_o)
    );

    logic [7:0]  mem [2048];
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          bad_addr = 0;
    logic [10:0] last_addr = '0;
    logic [7:0]  last_din = '0;

    always @(posedge clk) begin
        if (ce) begin
            acc_cnt <= acc_cnt + 1;
            if (int'(addr[5:0]) >= COLS || int'(addr[10:6]) >= LINES) bad_addr <= bad_addr + 1;
            if (wre) begin
                mem[addr] <= din;
                wr_cnt    <= wr_cnt + 1;
                last_addr <= addr;
                last_din  <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

    logic [7:0] scr [LINES][COLS];
    int mr = 0, mc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_scroll();
        for (int r = 0; r < LINES - 1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
        for (int c = 0; c < COLS; c++) scr[LINES - 1][c] = BLANK;
    endtask

    task automatic model_apply(input logic [7:0] c, output int b);
        b = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[mr][mc] = c;
            b = 1;
            if (mc < COLS - 1) mc++;
            else begin
                mc = 0;
                if (mr < LINES - 1) mr++;
                else begin
                    model_scroll();
                    b += SCROLL_CYC;
                end
            end
        end else if (c == 8'h0D) mc = 0;
        else if (c == 8'h0A) begin
            if (mr < LINES - 1) mr++;
            else begin
                model_scroll();
                b = SCROLL_CYC;
            end
        end else if (c == 8'h08) begin
            if (mc > 0) mc--;
        end else if (c == 8'h0C) begin
            for (int r = 0; r < LINES; r++)
                for (int k = 0; k < COLS; k++) scr[r][k] = BLANK;
            mr = 0;
            mc = 0;
            b = CLEAR_CYC;
        end
    endtask

    task automatic check_screen(input string name);
        int bad = 0;
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[{5'(r), 6'(c)}] !== scr[r][c]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic wait_idle(output int b);
        b = 0;
        @(negedge clk);
        while (!ready && b <= LIMIT) begin
            b++;
            @(negedge clk);
        end
        if (b > LIMIT) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: still busy after %0d cycles", b);
        end
    endtask

    task automatic send(input logic [7:0] c, output int b);
        @(negedge clk);
        ch  = c;
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        wait_idle(b);
    endtask

    task automatic do_char(input string name, input logic [7:0] c, output int b);
        int eb;
        model_apply(c, eb);
        send(c, b);
        chk({name, "_busy"}, b, eb);
        chk({name, "_row"}, int'(row), mr);
        chk({name, "_col"}, int'(col), mc);
    endtask

    // reset is held low on entry; FF is presented so it is taken on the first edge after release
    task automatic release_with_ff();
        int b, w0;
        int eb;
        ch  = 8'h0C;
        vld = 1'b1;
        w0  = wr_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("first_edge_accept", int'(busy_o), 1);
        vld = 1'b0;
        mr = 0;
        mc = 0;
        model_apply(8'h0C, eb);
        wait_idle(b);
        chk("ff_busy", b, eb);
        chk("ff_writes", wr_cnt - w0, CLEAR_CYC);
        chk("ff_cursor", {27'd0, row, col}, 0);
        check_screen("ff_screen");
    endtask

    typedef struct {
        logic [7:0] c;
        int         row;
        int         col;
        int         busy;
        int         acc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int b, a0, w0, rc;
        logic [7:0] c;
        tbl[0]  = '{8'h41, 0, 1, 1, 1};
        tbl[1]  = '{8'h0D, 0, 0, 0, 0};
        tbl[2]  = '{8'h08, 0, 0, 0, 0};
        tbl[3]  = '{8'h61, 0, 1, 1, 1};
        tbl[4]  = '{8'h62, 0, 2, 1, 1};
        tbl[5]  = '{8'h63, 0, 3, 1, 1};
        tbl[6]  = '{8'h08, 0, 2, 0, 0};
        tbl[7]  = '{8'h07, 0, 2, 0, 0};
        tbl[8]  = '{8'h0A, 1, 2, 0, 0};
        tbl[9]  = '{8'hFF, 1, 2, 0, 0};
        tbl[10] = '{8'h7E, 1, 3, 1, 1};
        tbl[11] = '{8'h7F, 1, 3, 0, 0};
        tbl[12] = '{8'h20, 1, 4, 1, 1};
        tbl[13] = '{8'h1F, 1, 4, 0, 0};
        tbl[14] = '{8'h08, 1, 3, 0, 0};

        #30;
        chk("reset_outputs", {22'd0, row, col, ce, wre, ready, busy_o}, 2);
        chk("reset_bus", {13'd0, addr, din}, 0);
        release_with_ff();

        for (int i = 0; i < 15; i++) begin
            a0 = acc_cnt;
            model_apply(tbl[i].c, rc);
            send(tbl[i].c, b);
            chk($sformatf("vec%0d_busy", i), b, tbl[i].busy);
            chk($sformatf("vec%0d_row", i), int'(row), tbl[i].row);
            chk($sformatf("vec%0d_col", i), int'(col), tbl[i].col);
            chk($sformatf("vec%0d_acc", i), acc_cnt - a0, tbl[i].acc);
            if (i == 0) begin
                chk("A_addr", int'(last_addr), 0);
                chk("A_din", int'(last_din), 8'h41);
            end
        end
        check_screen("table_screen");

        do_char("clr", 8'h0C, b);
        w0 = wr_cnt;
        for (int i = 0; i < COLS + 1; i++) do_char("line", 8'(8'h21 + i), b);
        chk("wrap_writes", wr_cnt - w0, COLS + 1);
        chk("wrap_cell", int'(mem[{5'd1, 6'd0}]), 8'h21 + COLS);
        chk("wrap_cursor", {27'd0, row, col}, {27'd0, 5'd1, 6'd1});

        for (int i = 0; i < 150; i++) begin
            rc = int'($urandom_range(0, 99));
            c = rc < 70 ? 8'($urandom_range(32, 126)) : rc < 78 ? 8'h0D : rc < 84 ? 8'h0A :
                rc < 92 ? 8'h08 : rc < 94 ? 8'h0C : 8'($urandom_range(0, 255));
            do_char("rand", c, b);
            if (i % 30 == 29) check_screen("rand_screen");
        end

        while (mr < LINES - 1) do_char("nav_lf", 8'h0A, b);
        do_char("nav_cr", 8'h0D, b);
        for (int i = 0; i < 5; i++) do_char("nav_ch", 8'($urandom_range(33, 126)), b);
        do_char("lf_scroll", 8'h0A, b);
        chk("lf_scroll_cycles", b, 1980);
        chk("lf_scroll_cursor", {27'd0, row, col}, {27'd0, 5'd16, 6'd5});
        chk("lf_scroll_blank", int'(mem[{5'd16, 6'd59}]), BLANK);
        check_screen("lf_scroll_screen");

        do_char("z_cr", 8'h0D, b);
        for (int i = 0; i < COLS - 1; i++) do_char("z_fill", 8'($urandom_range(33, 126)), b);
        chk("z_precol", int'(col), COLS - 1);
        do_char("z_scroll", 8'h5A, b);
        chk("z_cycles", b, 1981);
        chk("z_cell", int'(mem[{5'd15, 6'd59}]), 8'h5A);
        chk("z_cursor", {27'd0, row, col}, {27'd0, 5'd16, 6'd0});
        check_screen("z_screen");

        @(negedge clk);
        ch  = 8'h0A;
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        repeat (100) @(posedge clk);
        #5 rst_n = 1'b0;
        #1 chk("abort_ce", int'(ce), 0);
        chk("abort_state", {26'd0, row, col, ready, busy_o, wre}, 4);
        chk("abort_bus", {13'd0, addr, din}, 0);
        a0 = acc_cnt;
        repeat (3) @(posedge clk);
        #1 chk("abort_quiet", acc_cnt - a0, 0);
        release_with_ff();

        chk("addr_range", bad_addr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
